// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipe_stage pipeline register.
// PIPE_STAGE_SKID_EN (in pipe_stage.sv) selects the registered-ready skid variant.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CTRL_W = 5;
  localparam int unsigned DEF_REG_W  = 5;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline stage: load-enabled payload register
// with asynchronous clear of payload and control bits.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [REG_W-1:0]  d_wreg,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [REG_W-1:0]  q_wreg
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    wreg_d = wreg_q;
    if (ld) begin
      data_d = d_data;
      ctrl_d = d_ctrl;
      wreg_d = d_wreg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      ctrl_q <= '0;
      wreg_q <= '0;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      wreg_q <= wreg_d;
    end
  end

  assign q_data = data_q;
  assign q_ctrl = ctrl_q;
  assign q_wreg = wreg_q;

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid variant with registered in_ready.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned REG_W  = DEF_REG_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [REG_W-1:0]  in_wreg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [REG_W-1:0]  out_wreg,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, retire;

  logic              hd_ld;
  logic [DATA_W-1:0] hd_data;
  logic [CTRL_W-1:0] hd_ctrl;
  logic [REG_W-1:0]  hd_wreg;

`ifdef PIPE_STAGE_SKID_EN
  logic              sk_ld;
  logic [DATA_W-1:0] sk_data;
  logic [CTRL_W-1:0] sk_ctrl;
  logic [REG_W-1:0]  sk_wreg;
  logic              in_ready_q, in_ready_d;

  // Resets high so the first edge after reset can accept; gated low while in reset.
  assign in_ready = in_ready_q & ~rst;
`else
  assign in_ready = ~rst & (out_ready | ~out_valid);
`endif

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;
  assign stall_cnt = cnt_q;

  // Head slot is loaded with zero control whenever it empties, so bubbles carry no write enables.
  always_comb begin
    state_d = state_q;
    hd_ld   = 1'b0;
    hd_data = in_data;
    hd_ctrl = in_ctrl;
    hd_wreg = in_wreg;
`ifdef PIPE_STAGE_SKID_EN
    sk_ld   = 1'b0;
`endif
    if (flush) begin
      state_d = EMPTY;
      hd_ld   = 1'b1;
      hd_data = out_data;
      hd_ctrl = '0;
      hd_wreg = out_wreg;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            hd_ld   = 1'b1;
          end
        end
        FULL: begin
          if (accept && retire) begin
            hd_ld = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          end else if (accept) begin
            state_d = SKID;
            sk_ld   = 1'b1;
`endif
          end else if (retire) begin
            state_d = EMPTY;
            hd_ld   = 1'b1;
            hd_data = out_data;
            hd_ctrl = '0;
            hd_wreg = out_wreg;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          if (retire) begin
            state_d = FULL;
            hd_ld   = 1'b1;
            hd_data = sk_data;
            hd_ctrl = sk_ctrl;
            hd_wreg = sk_wreg;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_comb begin
    in_ready_d = (state_d != SKID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .REG_W(REG_W)) u_skid_slot (
    .clk    (clk),
    .rst    (rst),
    .ld     (sk_ld),
    .d_data (in_data),
    .d_ctrl (in_ctrl),
    .d_wreg (in_wreg),
    .q_data (sk_data),
    .q_ctrl (sk_ctrl),
    .q_wreg (sk_wreg)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .REG_W(REG_W)) u_head_slot (
    .clk    (clk),
    .rst    (rst),
    .ld     (hd_ld),
    .d_data (hd_data),
    .d_ctrl (hd_ctrl),
    .d_wreg (hd_wreg),
    .q_data (out_data),
    .q_ctrl (out_ctrl),
    .q_wreg (out_wreg)
  );

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage against a queue-based reference model;
// a second instance with a 4-bit stall counter exercises saturation.
module tb_pipe_stage;

`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_ctrl;
  logic [4:0]  in_wreg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_ctrl;
  logic [4:0]  out_wreg;
  logic [15:0] stall_cnt;

  logic        in_ready_s;
  logic        out_valid_s;
  logic [31:0] out_data_s;
  logic [4:0]  out_ctrl_s;
  logic [4:0]  out_wreg_s;
  logic [3:0]  stall_cnt_s;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  c;
    logic [4:0]  w;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_cnt;
  int unsigned m_cnt_s;
  int          errors;
  int          checks;

  pipe_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wreg(in_wreg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wreg(out_wreg),
    .stall_cnt(stall_cnt)
  );

  pipe_stage #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wreg(in_wreg),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_ctrl(out_ctrl_s), .out_wreg(out_wreg_s),
    .stall_cnt(stall_cnt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  // Model: a FIFO of capacity CAP holding accepted entries.
  function automatic logic exp_ready();
    if (rst) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    return (mq.size() < CAP);
`else
    return (mq.size() == 0) || out_ready;
`endif
  endfunction

  function automatic logic exp_valid();
    return (mq.size() != 0);
  endfunction

  function automatic logic [4:0] exp_ctrl();
    if (mq.size() == 0) return 5'd0;
    return mq[0].c;
  endfunction

  task automatic step();
    logic acc;
    logic ret;
    ent_t e;
    acc = in_valid && exp_ready();
    ret = exp_valid() && out_ready;
    if (exp_valid() && !out_ready) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_cnt_s < 15) m_cnt_s = m_cnt_s + 1;
    end
    e.d = in_data;
    e.c = in_ctrl;
    e.w = in_wreg;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (ret) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    in_wreg = '0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_cnt = 0;
    m_cnt_s = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rst_data: got %h want 0", out_data); end
    checks++; if (out_ctrl !== 5'd0 || out_wreg !== 5'd0) begin errors++; $display("FAIL rst_ctrl_wreg: got %b/%0d want 0/0", out_ctrl, out_wreg); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_cnt = 0;
    m_cnt_s = 0;
    // First edge after reset must accept.
    d = $urandom;
    in_valid = 1'b1; in_data = d; in_ctrl = 5'b10011; in_wreg = 5'd7;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== d) begin errors++; $display("FAIL post_rst_accept: got v=%b d=%h want v=1 d=%h", out_valid, out_data, d); end
    in_valid = 1'b0;
    step();
    step();
    checks++; if (stall_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL pre_rst_cnt: got %0d want %0d", stall_cnt, m_cnt); end
    // Asynchronous reset mid-stream while holding an entry.
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 5'd0) begin errors++; $display("FAIL mid_rst_out: got v=%b c=%b want v=0 c=0", out_valid, out_ctrl); end
    checks++; if (stall_cnt !== 16'd0 || stall_cnt_s !== 4'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d/%0d want 0/0", stall_cnt, stall_cnt_s); end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_cnt = 0;
    m_cnt_s = 0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_retire: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i); in_ctrl = 5'(i); in_wreg = 5'(i + 8);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'(i) || out_ctrl !== 5'(i) || out_wreg !== 5'(i + 8))
        begin errors++; $display("FAIL stream_out[%0d]: got v=%b d=%h c=%b w=%0d want v=1 d=%h", i, out_valid, out_data, out_ctrl, out_wreg, i); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 5'd0) begin errors++; $display("FAIL stream_drain: got v=%b c=%b want v=0 c=0", out_valid, out_ctrl); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; in_data = 32'hCAFE0000; in_ctrl = 5'b00101; in_wreg = 5'd3;
    step();
    in_valid = 1'b0; in_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hCAFE0000 || out_ctrl !== 5'b00101)
        begin errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h c=%b want v=1 d=cafe0000 c=00101", i, out_valid, out_data, out_ctrl); end
    end
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL bp_cnt: got %0d want 4", stall_cnt); end
    in_valid = 1'b1; in_data = 32'h00001234; in_ctrl = 5'b01000; in_wreg = 5'd9;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", in_ready); end
    checks++; if (out_data !== 32'hCAFE0000) begin errors++; $display("FAIL bp_head: got %h want cafe0000", out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== exp_valid() || (exp_valid() && out_data !== mq[0].d))
      begin errors++; $display("FAIL bp_release: got v=%b d=%h want v=%b", out_valid, out_data, exp_valid()); end
    step();
    checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL bp_end: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, stall_cnt, m_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_data = $urandom; in_ctrl = 5'b10101; in_wreg = 5'd4;
    step();
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 5'b00001; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 5'd0) begin errors++; $display("FAIL flush_full: got v=%b c=%b want v=0 c=0", out_valid, out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 5'b00001;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 5'd0) begin errors++; $display("FAIL flush_empty: got v=%b c=%b want v=0 c=0", out_valid, out_ctrl); end
    in_valid = 1'b1; in_data = 32'hA5A5; in_ctrl = 5'b11111; in_wreg = 5'd30;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5 || out_wreg !== 5'd30)
      begin errors++; $display("FAIL flush_resume: got v=%b d=%h w=%0d want v=1 d=a5a5 w=30", out_valid, out_data, out_wreg); end
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1; in_data = 32'hBEEF; in_ctrl = 5'b00010;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    checks++; if (stall_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d want 15", stall_cnt_s); end
    checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16: got %0d want 20", stall_cnt); end
    step();
    checks++; if (stall_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", stall_cnt_s); end
    out_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 25) == 0;
      in_data   = $urandom;
      in_ctrl   = 5'($urandom);
      in_wreg   = 5'($urandom);
      #1;
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, exp_ready()); end
      step();
      checks++;
      if (out_valid !== exp_valid() || out_ctrl !== exp_ctrl() ||
          (exp_valid() && (out_data !== mq[0].d || out_wreg !== mq[0].w))) begin
        errors++;
        $display("FAIL rnd_out[%0d]: got v=%b d=%h c=%b w=%0d want v=%b c=%b", i, out_valid, out_data, out_ctrl, out_wreg, exp_valid(), exp_ctrl());
      end
      checks++;
      if (stall_cnt !== 16'(m_cnt) || stall_cnt_s !== 4'(m_cnt_s)) begin
        errors++;
        $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt, stall_cnt_s, m_cnt, m_cnt_s);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_cnt = 0;
    m_cnt_s = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the datapath payload (ALU result, RegB data, PC+1 each carried in payload).
REQ-002 SHALL have parameter CTRL_W, default 5, width of the control-bit vector (reg_write, mem_read, mem_write, mem_to_reg, write_pc_4).
REQ-003 SHALL have parameter REG_W, default 5, width of the destination-register index.
REQ-004 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1), upstream handshake.
REQ-009 SHALL have ports in_data (input, DATA_W), in_ctrl (input, CTRL_W) and in_wreg (input, REG_W), upstream payload.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1), downstream handshake.
REQ-011 SHALL have ports out_data (output, DATA_W), out_ctrl (output, CTRL_W) and out_wreg (output, REG_W), downstream payload.
REQ-012 SHALL have port stall_cnt, output, CNT_W, count of cycles with out_valid=1 and out_ready=0.

Function
REQ-013 SHALL accept an entry on a rising clk edge when in_valid=1 and in_ready=1, and present it on out_* one cycle later (latency 1).
REQ-014 SHALL retire the head entry on a rising clk edge when out_valid=1 and out_ready=1.
REQ-015 SHALL keep out_data, out_ctrl and out_wreg stable while out_valid=1 and out_ready=0.
REQ-016 SHALL drive out_ctrl to all-zero whenever out_valid=0, so a bubble never asserts a write enable.
REQ-017 SHALL use states EMPTY and FULL (plus SKID when configured): EMPTY->FULL on accept; FULL->EMPTY on retire without accept; FULL->FULL on simultaneous accept and retire.
REQ-018 SHALL, when flush=1, go to EMPTY on that edge, drop any entry accepted in the same cycle, and set out_valid=0.
REQ-019 SHALL increment stall_cnt by 1 each cycle with out_valid=1 and out_ready=0, saturate at all-ones, and not wrap.
REQ-020 SHALL let flush take priority over accept and retire; stall_cnt is not affected by flush.

Reset
REQ-021 SHALL, while rst=1, asynchronously force state EMPTY, out_valid=0, out_data=0, out_ctrl=0, out_wreg=0 and stall_cnt=0.
REQ-022 SHALL drive in_ready=0 during reset.
REQ-023 SHALL discard in-flight entries on reset mid-operation, with no partial retire.
REQ-024 SHALL accept on the first clk edge after rst deasserts.

Configuration
REQ-025 SHALL provide macro PIPE_STAGE_SKID_EN to select the ready path.
REQ-026 With PIPE_STAGE_SKID_EN defined, SHALL add a second (skid) slot and state SKID: FULL->SKID on accept without retire; SKID->FULL on retire.
REQ-027 With PIPE_STAGE_SKID_EN defined, SHALL drive in_ready as a registered signal equal to (state != SKID), with no combinational out_ready->in_ready path.
REQ-028 Without PIPE_STAGE_SKID_EN, SHALL drive in_ready = out_ready OR NOT out_valid (combinational), with a single slot.

Structure
REQ-029 SHALL place the state enum (EMPTY, FULL, SKID) and default width constants in shared package pipe_pkg.
REQ-030 SHALL implement each storage slot as sub-module pipe_slot: load-enabled payload register with asynchronous clear of payload and control bits.

Verification
REQ-031 SHALL cover reset: rst pulse mid-stream with FULL state -> out_valid=0, out_ctrl=0, stall_cnt=0 within the same cycle.
REQ-032 SHALL cover streaming: out_ready=1, in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each, no bubbles.
REQ-033 SHALL cover backpressure: out_ready=0 for 4 cycles while holding 0xCAFE0000 -> out_data stable and stall_cnt=4; with skid, in_ready=0 after 2 accepts.
REQ-034 SHALL cover flush with simultaneous accept: flush=1 and in_valid=1 (data 0x55, ctrl=5'b00001) -> next cycle out_valid=0 and out_ctrl=0.
REQ-035 SHALL cover saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=15 held.
